// File: rtl/int_issue_queue_if.sv
// int_issue_queue_if: entry type and dispatch/issue/broadcast bundle for the integer issue queue.
package iiq_pkg;
  localparam int ROB_ID_WIDTH = 5;
  typedef struct packed {
    logic                    src1_valid;
    logic                    src1_ready;
    logic [ROB_ID_WIDTH-1:0] src1_rob_id;
    logic [31:0]             src1_data;
    logic                    src2_valid;
    logic                    src2_ready;
    logic [ROB_ID_WIDTH-1:0] src2_rob_id;
    logic [31:0]             src2_data;
    logic                    dst_valid;
    logic [ROB_ID_WIDTH-1:0] instr_rob_id;
    logic [3:0]              alu_op;
    logic [31:0]             imm;
  } iiq_entry_t;
endpackage

interface int_issue_queue_if;
  import iiq_pkg::*;
  logic                    dispatch_ready;
  logic                    dispatch_valid;
  iiq_entry_t              dispatch_data;
  logic                    issue_ready;
  logic                    issue_valid;
  iiq_entry_t              issue_data;
  logic                    iiq_wakeup_valid;
  logic [ROB_ID_WIDTH-1:0] iiq_wakeup_rob_id;
  logic                    alu_broadcast_valid;
  logic [ROB_ID_WIDTH-1:0] alu_broadcast_rob_id;
  logic [31:0]             alu_broadcast_reg_data;
  logic                    ld_broadcast_valid;
  logic [ROB_ID_WIDTH-1:0] ld_broadcast_rob_id;
  logic [31:0]             ld_broadcast_reg_data;
  logic                    flush;
  modport master(
    input  dispatch_ready, issue_valid, issue_data, iiq_wakeup_valid, iiq_wakeup_rob_id,
    output dispatch_valid, dispatch_data, issue_ready, alu_broadcast_valid, alu_broadcast_rob_id,
           alu_broadcast_reg_data, ld_broadcast_valid, ld_broadcast_rob_id, ld_broadcast_reg_data, flush
  );
  modport slave(
    output dispatch_ready, issue_valid, issue_data, iiq_wakeup_valid, iiq_wakeup_rob_id,
    input  dispatch_valid, dispatch_data, issue_ready, alu_broadcast_valid, alu_broadcast_rob_id,
           alu_broadcast_reg_data, ld_broadcast_valid, ld_broadcast_rob_id, ld_broadcast_reg_data, flush
  );
endinterface

// File: rtl/int_issue_queue.sv
// int_issue_queue: collapsing integer issue queue, oldest-ready select with broadcast wakeup and bypass.
module int_issue_queue
  import iiq_pkg::*;
#(
  parameter int N_ENTRIES = 8
) (
  input logic clk,
  input logic rst,
  int_issue_queue_if.slave io
);
  localparam int IW = $clog2(N_ENTRIES);
  localparam int CW = $clog2(N_ENTRIES + 1);
  localparam int RW = ROB_ID_WIDTH;
  iiq_entry_t q [N_ENTRIES];
  iiq_entry_t upd [N_ENTRIES];
  iiq_entry_t nq [N_ENTRIES];
  logic [CW-1:0] count;
  logic [N_ENTRIES-1:0] rdy;
  logic [IW-1:0] sel, wp;
  logic fire, accept;

  function automatic logic [31:0] pick(logic [RW-1:0] tag, logic [31:0] d, logic av, logic [RW-1:0] at,
                                       logic [31:0] ad, logic lv, logic [RW-1:0] lt, logic [31:0] ld);
    return (av && at == tag) ? ad : (lv && lt == tag) ? ld : d;
  endfunction

  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++)
      rdy[i] = (i < int'(count)) & (~q[i].src1_valid | q[i].src1_ready) & (~q[i].src2_valid | q[i].src2_ready);
    sel = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--)
      if (rdy[i]) sel = IW'(i);
  end

  assign io.issue_valid       = |rdy & ~io.flush & ~rst;
  assign fire                 = io.issue_valid & io.issue_ready;
  assign io.iiq_wakeup_valid  = fire & q[sel].dst_valid;
  assign io.iiq_wakeup_rob_id = q[sel].instr_rob_id;
  assign io.dispatch_ready    = (count != CW'(N_ENTRIES)) & ~rst;
  assign accept               = io.dispatch_valid & io.dispatch_ready & ~io.flush;
  assign wp                   = IW'(count - CW'(fire));

  always_comb begin
    io.issue_data = q[sel];
    if (q[sel].src1_valid)
      io.issue_data.src1_data = pick(q[sel].src1_rob_id, q[sel].src1_data, io.alu_broadcast_valid, io.alu_broadcast_rob_id,
                                     io.alu_broadcast_reg_data, io.ld_broadcast_valid, io.ld_broadcast_rob_id, io.ld_broadcast_reg_data);
    if (q[sel].src2_valid)
      io.issue_data.src2_data = pick(q[sel].src2_rob_id, q[sel].src2_data, io.alu_broadcast_valid, io.alu_broadcast_rob_id,
                                     io.alu_broadcast_reg_data, io.ld_broadcast_valid, io.ld_broadcast_rob_id, io.ld_broadcast_reg_data);
  end

  // ready comes only from our own wakeup or a load; ALU broadcasts supply data only
  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      upd[i] = q[i];
      if (q[i].src1_valid) begin
        upd[i].src1_ready = q[i].src1_ready | (io.iiq_wakeup_valid && io.iiq_wakeup_rob_id == q[i].src1_rob_id)
                          | (io.ld_broadcast_valid && io.ld_broadcast_rob_id == q[i].src1_rob_id);
        upd[i].src1_data  = pick(q[i].src1_rob_id, q[i].src1_data, io.alu_broadcast_valid, io.alu_broadcast_rob_id,
                                 io.alu_broadcast_reg_data, io.ld_broadcast_valid, io.ld_broadcast_rob_id, io.ld_broadcast_reg_data);
      end
      if (q[i].src2_valid) begin
        upd[i].src2_ready = q[i].src2_ready | (io.iiq_wakeup_valid && io.iiq_wakeup_rob_id == q[i].src2_rob_id)
                          | (io.ld_broadcast_valid && io.ld_broadcast_rob_id == q[i].src2_rob_id);
        upd[i].src2_data  = pick(q[i].src2_rob_id, q[i].src2_data, io.alu_broadcast_valid, io.alu_broadcast_rob_id,
                                 io.alu_broadcast_reg_data, io.ld_broadcast_valid, io.ld_broadcast_rob_id, io.ld_broadcast_reg_data);
      end
    end
    for (int i = 0; i < N_ENTRIES - 1; i++)
      nq[i] = (fire && i >= int'(sel)) ? upd[i+1] : upd[i];
    nq[N_ENTRIES-1] = upd[N_ENTRIES-1];
    if (accept) nq[wp] = io.dispatch_data;
  end

  always_ff @(posedge clk) begin
    count <= (rst | io.flush) ? '0 : count + CW'(accept) - CW'(fire);
    q <= nq;
  end
endmodule

// File: tb/tb_int_issue_queue.sv
// tb_int_issue_queue: directed scenario tests for the integer issue queue.
module tb_int_issue_queue;
  import iiq_pkg::*;
  logic clk = 0;
  logic rst = 1;
  int vec = 0;
  int errs = 0;
  int_issue_queue_if io();
  int_issue_queue #(.N_ENTRIES(8)) dut (.clk(clk), .rst(rst), .io(io));
  always #5 clk = ~clk;

  function automatic iiq_entry_t mk(int rob, bit dst, bit s1v, bit s1r, int s1t, bit s2v, bit s2r, int s2t);
    iiq_entry_t e;
    e = '0;
    e.instr_rob_id = ROB_ID_WIDTH'(rob);
    e.dst_valid    = dst;
    e.src1_valid   = s1v;
    e.src1_ready   = s1r;
    e.src1_rob_id  = ROB_ID_WIDTH'(s1t);
    e.src1_data    = 32'hA000_0000 | 32'(rob);
    e.src2_valid   = s2v;
    e.src2_ready   = s2r;
    e.src2_rob_id  = ROB_ID_WIDTH'(s2t);
    e.src2_data    = 32'hB000_0000 | 32'(rob);
    e.imm          = 32'(rob * 3);
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    io.dispatch_valid = 0;
    io.dispatch_data = '0;
    io.issue_ready = 0;
    io.alu_broadcast_valid = 0;
    io.alu_broadcast_rob_id = '0;
    io.alu_broadcast_reg_data = '0;
    io.ld_broadcast_valid = 0;
    io.ld_broadcast_rob_id = '0;
    io.ld_broadcast_reg_data = '0;
    io.flush = 0;
  endtask

  task automatic drain();
    idle();
    io.flush = 1;
    cyc();
    io.flush = 0;
  endtask

  task automatic push(iiq_entry_t e);
    io.dispatch_valid = 1;
    io.dispatch_data = e;
    cyc();
    io.dispatch_valid = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    io.dispatch_valid = 1;
    io.dispatch_data = mk(1, 1, 0, 0, 0, 0, 0, 0);
    io.issue_ready = 1;
    repeat (2) cyc();
    vec++; if (io.dispatch_ready !== 1'b0) begin errs++; $display("FAIL rst_dispatch_ready got %b exp 0", io.dispatch_ready); end
    vec++; if (io.issue_valid !== 1'b0) begin errs++; $display("FAIL rst_issue_valid got %b exp 0", io.issue_valid); end
    vec++; if (io.iiq_wakeup_valid !== 1'b0) begin errs++; $display("FAIL rst_wakeup got %b exp 0", io.iiq_wakeup_valid); end
    rst = 0;
    idle();
    #1;
    vec++; if (io.dispatch_ready !== 1'b1) begin errs++; $display("FAIL post_rst_dispatch_ready got %b exp 1", io.dispatch_ready); end
    vec++; if (io.issue_valid !== 1'b0) begin errs++; $display("FAIL post_rst_issue_valid got %b exp 0", io.issue_valid); end
    vec++; if (dut.count !== 4'd0) begin errs++; $display("FAIL post_rst_count got %0d exp 0", dut.count); end
  endtask

  task automatic test_in_order();
    for (int r = 1; r <= 3; r++) push(mk(r, 1, 0, 0, 0, 0, 0, 0));
    io.issue_ready = 1;
    for (int r = 1; r <= 3; r++) begin
      #1;
      vec++; if (io.issue_valid !== 1'b1 || io.issue_data.instr_rob_id !== 5'(r)) begin errs++; $display("FAIL in_order_issue got v=%b rob=%0d exp v=1 rob=%0d", io.issue_valid, io.issue_data.instr_rob_id, r); end
      vec++; if (io.iiq_wakeup_valid !== 1'b1 || io.iiq_wakeup_rob_id !== 5'(r)) begin errs++; $display("FAIL in_order_wakeup got v=%b rob=%0d exp v=1 rob=%0d", io.iiq_wakeup_valid, io.iiq_wakeup_rob_id, r); end
      cyc();
    end
    vec++; if (io.issue_valid !== 1'b0) begin errs++; $display("FAIL in_order_empty got %b exp 0", io.issue_valid); end
    idle();
  endtask

  task automatic test_dependency();
    push(mk(5, 1, 0, 0, 0, 0, 0, 0));
    push(mk(6, 1, 1, 0, 5, 0, 0, 0));
    io.issue_ready = 1;
    #1;
    vec++; if (io.issue_data.instr_rob_id !== 5'd5 || io.iiq_wakeup_valid !== 1'b1 || io.iiq_wakeup_rob_id !== 5'd5) begin errs++; $display("FAIL dep_a_fire got rob=%0d wv=%b wrob=%0d exp 5 1 5", io.issue_data.instr_rob_id, io.iiq_wakeup_valid, io.iiq_wakeup_rob_id); end
    cyc();
    io.alu_broadcast_valid = 1;
    io.alu_broadcast_rob_id = 5'd5;
    io.alu_broadcast_reg_data = 32'hDEADBEEF;
    #1;
    vec++; if (io.issue_valid !== 1'b1 || io.issue_data.instr_rob_id !== 5'd6) begin errs++; $display("FAIL dep_b_valid got v=%b rob=%0d exp v=1 rob=6", io.issue_valid, io.issue_data.instr_rob_id); end
    vec++; if (io.issue_data.src1_data !== 32'hDEADBEEF) begin errs++; $display("FAIL dep_bypass got %h exp deadbeef", io.issue_data.src1_data); end
    cyc();
    idle();
    #1;
    vec++; if (io.issue_valid !== 1'b0 || dut.count !== 4'd0) begin errs++; $display("FAIL dep_drained got v=%b cnt=%0d exp 0 0", io.issue_valid, dut.count); end
  endtask

  task automatic test_oldest_ready();
    push(mk(10, 1, 1, 0, 20, 0, 0, 0));
    push(mk(11, 1, 0, 0, 0, 0, 0, 0));
    io.issue_ready = 1;
    #1;
    vec++; if (io.issue_valid !== 1'b1 || io.issue_data.instr_rob_id !== 5'd11) begin errs++; $display("FAIL oldest_sel got v=%b rob=%0d exp v=1 rob=11", io.issue_valid, io.issue_data.instr_rob_id); end
    vec++; if (dut.count !== 4'd2) begin errs++; $display("FAIL oldest_cnt_before got %0d exp 2", dut.count); end
    cyc();
    vec++; if (dut.count !== 4'd1 || io.issue_valid !== 1'b0) begin errs++; $display("FAIL oldest_after got cnt=%0d v=%b exp 1 0", dut.count, io.issue_valid); end
    vec++; if (dut.q[0].instr_rob_id !== 5'd10) begin errs++; $display("FAIL oldest_slot0 got %0d exp 10", dut.q[0].instr_rob_id); end
    drain();
  endtask

  task automatic test_full();
    for (int r = 0; r < 8; r++) begin
      vec++; if (io.dispatch_ready !== 1'b1) begin errs++; $display("FAIL full_fill_ready%0d got %b exp 1", r, io.dispatch_ready); end
      push(mk(r, 0, 0, 0, 0, 0, 0, 0));
    end
    vec++; if (io.dispatch_ready !== 1'b0 || dut.count !== 4'd8) begin errs++; $display("FAIL full_state got rdy=%b cnt=%0d exp 0 8", io.dispatch_ready, dut.count); end
    io.issue_ready = 1;
    io.dispatch_valid = 1;
    io.dispatch_data = mk(30, 0, 0, 0, 0, 0, 0, 0);
    #1;
    vec++; if (io.dispatch_ready !== 1'b0 || io.issue_data.instr_rob_id !== 5'd0) begin errs++; $display("FAIL full_fire got rdy=%b rob=%0d exp 0 0", io.dispatch_ready, io.issue_data.instr_rob_id); end
    cyc();
    io.dispatch_data = mk(31, 0, 0, 0, 0, 0, 0, 0);
    #1;
    vec++; if (io.dispatch_ready !== 1'b1 || dut.count !== 4'd7 || io.issue_data.instr_rob_id !== 5'd1) begin errs++; $display("FAIL full_after_fire got rdy=%b cnt=%0d rob=%0d exp 1 7 1", io.dispatch_ready, dut.count, io.issue_data.instr_rob_id); end
    cyc();
    idle();
    #1;
    vec++; if (dut.count !== 4'd7 || dut.q[6].instr_rob_id !== 5'd31 || dut.q[0].instr_rob_id !== 5'd2) begin errs++; $display("FAIL full_fire_disp got cnt=%0d q6=%0d q0=%0d exp 7 31 2", dut.count, dut.q[6].instr_rob_id, dut.q[0].instr_rob_id); end
    drain();
  endtask

  task automatic test_load_wake();
    io.issue_ready = 1;
    push(mk(12, 1, 0, 0, 0, 1, 0, 9));
    #1;
    vec++; if (io.issue_valid !== 1'b0) begin errs++; $display("FAIL ld_wait got %b exp 0", io.issue_valid); end
    io.ld_broadcast_valid = 1;
    io.ld_broadcast_rob_id = 5'd9;
    io.ld_broadcast_reg_data = 32'h1234;
    #1;
    vec++; if (io.issue_valid !== 1'b0) begin errs++; $display("FAIL ld_same_cycle got %b exp 0", io.issue_valid); end
    cyc();
    io.ld_broadcast_valid = 0;
    #1;
    vec++; if (io.issue_valid !== 1'b1 || io.issue_data.instr_rob_id !== 5'd12) begin errs++; $display("FAIL ld_issue got v=%b rob=%0d exp 1 12", io.issue_valid, io.issue_data.instr_rob_id); end
    vec++; if (io.issue_data.src2_data !== 32'h1234) begin errs++; $display("FAIL ld_data got %h exp 00001234", io.issue_data.src2_data); end
    cyc();
    vec++; if (dut.count !== 4'd0) begin errs++; $display("FAIL ld_drained got %0d exp 0", dut.count); end
    idle();
  endtask

  task automatic test_flush();
    for (int r = 40; r < 44; r++) push(mk(r, 1, 0, 0, 0, 0, 0, 0));
    vec++; if (dut.count !== 4'd4) begin errs++; $display("FAIL flush_pre_cnt got %0d exp 4", dut.count); end
    io.flush = 1;
    io.dispatch_valid = 1;
    io.dispatch_data = mk(50, 1, 0, 0, 0, 0, 0, 0);
    io.issue_ready = 1;
    #1;
    vec++; if (io.issue_valid !== 1'b0 || io.iiq_wakeup_valid !== 1'b0) begin errs++; $display("FAIL flush_cycle got v=%b wv=%b exp 0 0", io.issue_valid, io.iiq_wakeup_valid); end
    cyc();
    idle();
    io.issue_ready = 1;
    #1;
    vec++; if (dut.count !== 4'd0 || io.issue_valid !== 1'b0 || io.dispatch_ready !== 1'b1) begin errs++; $display("FAIL flush_after got cnt=%0d v=%b rdy=%b exp 0 0 1", dut.count, io.issue_valid, io.dispatch_ready); end
    idle();
  endtask

  task automatic test_reset_mid();
    push(mk(1, 1, 0, 0, 0, 0, 0, 0));
    push(mk(2, 1, 0, 0, 0, 0, 0, 0));
    rst = 1;
    cyc();
    rst = 0;
    #1;
    vec++; if (dut.count !== 4'd0 || io.issue_valid !== 1'b0 || io.dispatch_ready !== 1'b1) begin errs++; $display("FAIL reset_mid got cnt=%0d v=%b rdy=%b exp 0 0 1", dut.count, io.issue_valid, io.dispatch_ready); end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_dependency();
    test_oldest_ready();
    test_full();
    test_load_wake();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
